// File: rtl/vec_data_mem_resp_pkg.sv
// Shared types and constants for the vector CPU data-memory responder.
package vec_data_mem_resp_pkg;

    // Width of one stored data word.
    localparam int WORD_W = 32;

    // Top-level control state: sweeping the array to zero, or serving accesses.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_state_t;

endpackage

// File: rtl/vec_data_mem_resp_mem_word_array.sv
// Single-write, single-read synchronous word array with read-first behaviour
// and a registered read port.
module mem_word_array
    import vec_data_mem_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Write the addressed word and register the read word on every clock.
    // NOTE: the storage has no reset branch so it can map onto block RAM;
    // the owner zeroes it with a sweep instead.
    // NOTE: non-blocking assignments make the read sample the pre-write
    // contents, which is exactly the read-first behaviour on an address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vec_data_mem_resp.sv
// Data-memory responder for the vector CPU load/store port: clear sweep after
// reset, CPU read/write with fixed read latency, and a preload port that
// yields to CPU writes.
module vec_data_mem_resp
    import vec_data_mem_resp_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    input  logic [WORD_W-1:0] cpu_data,
    input  logic              wr_enable,
    output logic [WORD_W-1:0] mem_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    output logic              init_done,
    output logic              err_oob
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam mem_state_t        RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    mem_state_t        state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;

    logic [ADDR_W-1:0] cpu_idx;
    logic              cpu_oob;
    logic              unused_addr_bits;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;

    logic              rd_ok;
    logic              rd_vld;
    logic [WORD_W-1:0] read_word;

    // Byte address to word index; anything above the array's range is an error.
    assign cpu_idx          = cpu_addr[ADDR_W+1:2];
    assign cpu_oob          = |cpu_addr[31:ADDR_W+2];
    assign unused_addr_bits = ^cpu_addr[1:0];

    // State and clear-counter register; reset restarts the sweep from word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next state, array write arbitration and status outputs.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        arr_we      = 1'b0;
        arr_waddr   = clr_cnt;
        arr_wdata   = '0;
        rd_ok       = 1'b0;
        ld_ready    = 1'b0;
        init_done   = 1'b0;
        err_oob     = 1'b0;

        // A cycle with reset high does nothing; the register block restarts everything.
        if (!reset) begin
            case (state)
                CLEAR: begin
                    arr_we      = 1'b1;
                    arr_waddr   = clr_cnt;
                    clr_cnt_nxt = clr_cnt + 1'b1;
                    if (clr_cnt == LAST_IDX) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    init_done = 1'b1;
                    err_oob   = cpu_oob;
                    rd_ok     = !cpu_oob;
                    ld_ready  = !wr_enable;
                    if (wr_enable) begin
                        // Out-of-range CPU writes are dropped.
                        if (!cpu_oob) begin
                            arr_we    = 1'b1;
                            arr_waddr = cpu_idx;
                            arr_wdata = cpu_data;
                        end
                    end else if (ld_valid) begin
                        arr_we    = 1'b1;
                        arr_waddr = ld_addr;
                        arr_wdata = ld_data;
                    end
                end
                default: begin
                    state_nxt = RST_STATE;
                end
            endcase
        end
    end

    mem_word_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (cpu_idx),
        .rdata (arr_rdata)
    );

    // Track whether the word now leaving the array belongs to a valid read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_ok;
        end
    end

    // Reads issued during CLEAR or out of range return zero.
    assign read_word = rd_vld ? arr_rdata : '0;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [WORD_W-1:0] out_q;

            // Extra output register stage for the two-cycle latency variant.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_q <= '0;
                end else begin
                    out_q <= read_word;
                end
            end

            assign mem_data = out_q;
        end else begin : g_lat1
            assign mem_data = read_word;
        end
    endgenerate

endmodule
